// File: rtl/dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported data
//               memory (A = CPU load/store, B = debug/loader), with access
//               legality checking and registered load data.
//               Optional macro DMEM_ARB_LOCK_EN adds B_LOCK (loader priority hold).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 2048
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [2:0]  A_FUNC3,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_WDATA,
  output logic        A_GNT,
  output logic        A_DONE,
  output logic        A_ERR,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [2:0]  B_FUNC3,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_WDATA,
  output logic        B_GNT,
  output logic        B_DONE,
  output logic        B_ERR,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        B_LOCK,
`endif
  output logic [31:0] RDATA,
  output logic        MRd,
  output logic        MWrt,
  output logic [2:0]  FUNC3,
  output logic [31:0] IN_ADDR,
  output logic [31:0] W_DATA,
  input  logic [31:0] R_DATA
);

  localparam logic [31:0] c_addr_limit = 32'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_decide;
  logic        w_pick_b;
  logic        w_hold_b;
  logic        w_sel_we;
  logic [2:0]  w_sel_func3;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_err;

  logic        r_a_next;
  logic        r_win_b;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  // Rejects out-of-range, misaligned and unsupported-width accesses.
  function automatic logic cmd_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic bad_f3;
    logic mis;
    bad_f3 = we ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    case (f3)
      3'b010:         mis = (addr[1:0] != 2'b00);
      3'b001, 3'b101: mis = addr[0];
      default:        mis = 1'b0;
    endcase
    return (addr >= c_addr_limit) || bad_f3 || mis;
  endfunction

`ifdef DMEM_ARB_LOCK_EN
  assign w_hold_b = B_LOCK && r_win_b;
`else
  assign w_hold_b = 1'b0;
`endif

  assign w_pick_b    = B_REQ && (!A_REQ || !r_a_next || w_hold_b);
  assign w_sel_we    = w_pick_b ? B_WE    : A_WE;
  assign w_sel_func3 = w_pick_b ? B_FUNC3 : A_FUNC3;
  assign w_sel_addr  = w_pick_b ? B_ADDR  : A_ADDR;
  assign w_sel_wdata = w_pick_b ? B_WDATA : A_WDATA;
  assign w_sel_err   = cmd_err(w_sel_we, w_sel_func3, w_sel_addr);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_decide    = 1'b0;
    A_GNT       = 1'b0;
    B_GNT       = 1'b0;
    A_DONE      = 1'b0;
    B_DONE      = 1'b0;
    A_ERR       = 1'b0;
    B_ERR       = 1'b0;
    MRd         = 1'b0;
    MWrt        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          A_DONE = !r_win_b;
          B_DONE = r_win_b;
          A_ERR  = !r_win_b && r_err;
          B_ERR  = r_win_b && r_err;
        end
        w_decide    = A_REQ || B_REQ;
        w_state_nxt = w_decide ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        A_GNT       = !r_win_b;
        B_GNT       = r_win_b;
        MRd         = !r_we && !r_err;
        MWrt        = r_we && !r_err;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command is captured only on the grant edge; requesters hold it until then.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a_next <= 1'b1;
      r_win_b  <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_func3  <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      if (w_decide) begin
        r_a_next <= w_pick_b;
        r_win_b  <= w_pick_b;
        r_we     <= w_sel_we;
        r_err    <= w_sel_err;
        r_func3  <= w_sel_func3;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= (!r_we && !r_err) ? R_DATA : 32'h0;
      end
    end
  end

  assign RDATA   = r_rdata;
  assign FUNC3   = r_func3;
  assign IN_ADDR = r_addr;
  assign W_DATA  = r_wdata;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 2048, meaning the byte-address bound of data memory (512 words); ADDR >= ADDR_LIMIT is out of range.
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports A_REQ/B_REQ  input  1 each  access request, port A = CPU load/store, port B = debug/loader.
REQ-005 SHALL have ports A_WE/B_WE  input  1 each  1 = store, 0 = load.
REQ-006 SHALL have ports A_FUNC3/B_FUNC3  input  3 each  RISC-V load/store funct3.
REQ-007 SHALL have ports A_ADDR/B_ADDR  input  32 each  byte address.
REQ-008 SHALL have ports A_WDATA/B_WDATA  input  32 each  store data.
REQ-009 SHALL have ports A_GNT/B_GNT  output  1 each  one-cycle pulse: command accepted.
REQ-010 SHALL have ports A_DONE/B_DONE  output  1 each  one-cycle completion pulse.
REQ-011 SHALL have ports A_ERR/B_ERR  output  1 each  valid with DONE; access rejected.
REQ-012 SHALL have port RDATA  output  32  load result, valid with either DONE.
REQ-013 SHALL have memory-side outputs MRd 1, MWrt 1, FUNC3 3, IN_ADDR 32, W_DATA 32, and input R_DATA 32 (combinational read, write on rising CLK).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-015 In IDLE or DONE with any REQ high, SHALL pick one winner, latch its WE/FUNC3/ADDR/WDATA, pulse its GNT in the following cycle, and enter ACCESS; with no REQ, go/stay IDLE.
REQ-016 Arbitration SHALL be round-robin: when both request, the port not granted last wins; after reset, A wins first.
REQ-017 A lone requester SHALL be granted regardless of history.
REQ-018 Requester SHALL hold REQ and command stable until GNT; the arbiter samples the command only on the grant edge.
REQ-019 In ACCESS, SHALL drive IN_ADDR/FUNC3/W_DATA from latched values and assert exactly one of MRd (load) or MWrt (store) for exactly one cycle, then enter DONE.
REQ-020 At the end of ACCESS, SHALL register R_DATA into RDATA for loads; RDATA SHALL be 0 after stores or errors.
REQ-021 In DONE, SHALL pulse the winner's DONE (and ERR if rejected) for one cycle; latency from REQ sampled in IDLE to DONE = 3 cycles; back-to-back throughput = 1 access per 2 cycles.
REQ-022 Out-of-range address, misaligned word (ADDR[1:0]!=0 for funct3 010), misaligned half (ADDR[0]=1 for 001/101), or unsupported funct3 (load: 011/110/111; store: above 010) SHALL be rejected: no MRd/MWrt, ERR=1 with DONE.
REQ-023 MRd, MWrt, all GNT/DONE/ERR SHALL be 0 in every cycle not specified above; MRd and MWrt SHALL never be high simultaneously.
REQ-024 A REQ dropped before GNT SHALL be forgotten with no side effects.

Reset
REQ-025 RESET_N low SHALL immediately force IDLE, all outputs 0, RDATA 0, round-robin pointer to "A next", independent of CLK.
REQ-026 Reset during ACCESS SHALL abort the access: MWrt deasserts asynchronously, no DONE is ever issued for it.
REQ-027 Requests held across reset deassertion SHALL be arbitrated normally from the first clock edge after release.

Configuration
REQ-028 With DMEM_ARB_LOCK_EN defined, SHALL add input B_LOCK (1 bit): while B_LOCK is high at a decision point after a B grant, B keeps priority over A (atomic loader sequences); A is served once B_LOCK is low or B_REQ is low.
REQ-029 Without DMEM_ARB_LOCK_EN, B_LOCK SHALL not exist and pure round-robin applies.

Verification
REQ-030 A load: A_REQ, FUNC3=010, ADDR=0x10, memory word 0xDEADBEEF -> MRd one cycle with IN_ADDR=0x10, A_DONE 3 cycles after request, RDATA=0xDEADBEEF, A_ERR=0.
REQ-031 Both REQ held continuously from reset release -> grant order A,B,A,B; one DONE every 2 cycles.
REQ-032 B store FUNC3=010, ADDR=0x802 -> no MWrt, B_DONE with B_ERR=1, RDATA=0.
REQ-033 RESET_N low in ACCESS of A store 0x12345678 -> MWrt drops immediately, no A_DONE, next grant after release goes to A.
REQ-034 With DMEM_ARB_LOCK_EN, B_LOCK=1, both REQ held -> B granted 4 consecutive times; B_LOCK=0 -> next grant A.
REQ-035 A_REQ pulsed one cycle while B access in progress -> no A_GNT, no memory access on A's behalf.
